// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB initiator bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  // Number of low address bits below one data word, cleared on PADDR.
  function automatic int unsigned apb_addr_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait limiter: loads the limit on clear, counts down on each
// stalled cycle and flags expiry at terminal count zero.
module apb_timeout_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= i_limit;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/master_to_apb.sv
// Initiator-side APB bridge: one valid/ready request in, one SETUP/ACCESS
// transfer out, one valid/ready response back. Optional ACCESS timeout is
// enabled by defining MASTER_TO_APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | PSEL high, PENABLE low, single cycle
// ACCESS | PSEL and PENABLE high, waiting on PREADY (or timeout)
// RESP   | rsp_valid high, holding data/error until rsp_ready
module master_to_apb
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int unsigned ADDR_LSB = apb_addr_lsb(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ADDR_LSB;

  apb_mst_state_t          r_state;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [DATA_WIDTH/8-1:0] r_pstrb;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;
  logic                    w_expired;

`ifdef MASTER_TO_APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic w_to_clear;
  logic w_to_enable;

  assign w_to_clear  = (r_state == SETUP);
  assign w_to_enable = (r_state == ACCESS) && !PREADY;

  apb_timeout_cnt #(.CNT_W(TO_W)) u_timeout (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .i_clear   (w_to_clear),
    .i_enable  (w_to_enable),
    .i_limit   (TO_W'(TIMEOUT_CYCLES)),
    .o_expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_paddr  <= req_addr & ALIGN_MASK;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
            r_pstrb  <= req_write ? req_wstrb : '0;
            r_psel   <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // A real PREADY wins over expiry in the limit cycle.
          if (PREADY) begin
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= PSLVERR;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (w_expired) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PADDR     = r_paddr;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;

endmodule
